// File: rtl/barrett_mu_precompute.sv
// Barrett constant precompute: finds the bit-length k of modulus m and computes
// mu = floor(2^(2k) / m) by restoring long division, one quotient bit per cycle.
module barrett_mu_precompute #(
    parameter int WIDTH = 64,
    parameter int KW    = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] m_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic             error_o,
    output logic [WIDTH-1:0] m_o,
    output logic [WIDTH+1:0] mu_o,
    output logic [KW-1:0]    k_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_DIV,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] ms_q;
    logic [KW-1:0]    shift_cnt_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH:0]   r_q;
    logic [WIDTH+1:0] q_q;
    logic [KW:0]      cnt_q;
    logic             dbit_q;
    logic             busy_q;
    logic             valid_q;
    logic             error_q;

    logic [WIDTH:0]   t_d;
    logic [WIDTH:0]   diff_d;
    logic             ge_d;
    logic [KW-1:0]    k_d;

    // One restoring-division step; the remainder never reaches m, so its top bit stays 0.
    always_comb begin
        t_d    = {r_q[WIDTH-1:0], dbit_q};
        ge_d   = r_q[WIDTH] | (t_d >= {1'b0, m_q});
        diff_d = t_d - {1'b0, m_q};
        k_d    = KW'(WIDTH) - shift_cnt_q;
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            m_q         <= '0;
            ms_q        <= '0;
            shift_cnt_q <= '0;
            k_q         <= '0;
            r_q         <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            dbit_q      <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    valid_q <= 1'b0;
                    if (start_i) begin
                        m_q         <= m_i;
                        ms_q        <= m_i;
                        shift_cnt_q <= '0;
                        busy_q      <= 1'b1;
                        if (m_i < WIDTH'(2)) begin
                            error_q <= 1'b1;
                            q_q     <= '0;
                            k_q     <= '0;
                            valid_q <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            error_q <= 1'b0;
                            state_q <= S_NORM;
                        end
                    end
                end
                S_NORM: begin
                    if (ms_q[WIDTH-1]) begin
                        k_q     <= k_d;
                        r_q     <= '0;
                        q_q     <= '0;
                        cnt_q   <= {k_d, 1'b0};
                        dbit_q  <= 1'b1;
                        state_q <= S_DIV;
                    end else begin
                        ms_q        <= ms_q << 1;
                        shift_cnt_q <= shift_cnt_q + KW'(1);
                    end
                end
                S_DIV: begin
                    dbit_q <= 1'b0;
                    r_q    <= ge_d ? diff_d : t_d;
                    q_q    <= {q_q[WIDTH:0], ge_d};
                    cnt_q  <= cnt_q - (KW + 1)'(1);
                    if (cnt_q == '0) begin
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    assign error_o = error_q;
    assign m_o     = m_q;
    assign mu_o    = q_q;
    assign k_o     = k_q;

endmodule
